// File: rtl/md_seq_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: op-select bit
// indices, FSM state encoding and small operand helpers.
package md_seq_ctrl_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned MD_OP_W = 7;

  // md_op one-hot bit positions
  localparam int unsigned MD_MUL_W   = 0;
  localparam int unsigned MD_MULH_W  = 1;
  localparam int unsigned MD_MULH_WU = 2;
  localparam int unsigned MD_DIV_W   = 3;
  localparam int unsigned MD_MOD_W   = 4;
  localparam int unsigned MD_DIV_WU  = 5;
  localparam int unsigned MD_MOD_WU  = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  // True when exactly one bit of the op select is set.
  function automatic logic is_one_hot(input logic [MD_OP_W-1:0] v);
    return (v != '0) && ((v & (v - MD_OP_W'(1))) == '0);
  endfunction

  // Magnitude of v; only negated when the op is signed and v is negative.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/md_seq_ctrl_div_iter.sv
// Radix-2 restoring divider datapath on unsigned magnitudes.
// Ports: clk/rst (sync, active-high); load captures dividend/divisor
// magnitudes; step retires one quotient bit; quo/rem are the magnitudes.
module div_iter
  import md_seq_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);

  logic [XLEN-1:0] quo_q, rem_q, dsr_q;
  logic [XLEN:0]   shifted_c;
  logic [XLEN:0]   trial_c;

  // Quotient register doubles as the dividend shift register.
  assign shifted_c = {rem_q, quo_q[XLEN-1]};
  assign trial_c   = shifted_c - {1'b0, dsr_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dsr_q <= divisor;
    end else if (step) begin
      // Negative trial (bit XLEN set) restores the shifted remainder.
      if (!trial_c[XLEN]) begin
        rem_q <= trial_c[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= shifted_c[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  assign quo = quo_q;
  assign rem = rem_q;

endmodule

// File: rtl/md_seq_ctrl.sv
// Multi-cycle multiply/divide sequencer for the EX stage.
// Accepts one one-hot mul/div op, runs it, holds the result until consumed.
// Ports: clk, rst (sync active-high); md_valid/md_op/src1/src2 op request;
// flush abandons work; out_ready consumes result; md_ready (idle),
// md_busy (not idle), cul_done (md_res valid), md_res (registered result).
// Build option: MD_EARLY_OUT_EN lets trivially small divides skip the loop.
module md_seq_ctrl
  import md_seq_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT  = 2,
  parameter int unsigned DIV_ITER = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               md_valid,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [XLEN-1:0]    src1,
  input  logic [XLEN-1:0]    src2,
  input  logic               flush,
  input  logic               out_ready,
  output logic               md_ready,
  output logic               md_busy,
  output logic               cul_done,
  output logic [XLEN-1:0]    md_res
);

  md_state_e          state_q, state_d;
  logic [MD_OP_W-1:0] op_q;
  logic [XLEN-1:0]    op1_q, op2_q;
  logic [31:0]        cnt_q;
  logic               early_q;

  logic               accept_c;
  logic               in_is_mul_c, in_sgn_c, early_c;
  logic [XLEN-1:0]    in_a_mag_c, in_b_mag_c;
  logic [XLEN-1:0]    div_quo, div_rem;
  logic [2*XLEN-1:0]  prod_c;
  logic [2*XLEN-1:0]  mul_a_c, mul_b_c;
  logic               sgn_div_c;
  logic [XLEN-1:0]    q_mag_c, r_mag_c, q_fix_c, r_fix_c, res_c;

  // Request decode
  assign accept_c    = (state_q == ST_IDLE) && md_valid && is_one_hot(md_op) && !flush;
  assign in_is_mul_c = md_op[MD_MUL_W] | md_op[MD_MULH_W] | md_op[MD_MULH_WU];
  assign in_sgn_c    = md_op[MD_DIV_W] | md_op[MD_MOD_W];
  assign in_a_mag_c  = mag(src1, in_sgn_c);
  assign in_b_mag_c  = mag(src2, in_sgn_c);

`ifdef MD_EARLY_OUT_EN
  // |dividend| < |divisor| means quotient 0 and remainder = dividend.
  assign early_c = !in_is_mul_c && (src2 != '0) && (in_a_mag_c < in_b_mag_c);
`else
  assign early_c = 1'b0;
`endif

  // Next-state logic; flush wins over everything else
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (in_is_mul_c)  state_d = ST_MUL;
          else if (early_c) state_d = ST_FIX;
          else              state_d = ST_DIV;
        end
      end
      ST_MUL:  if (cnt_q == 32'd1) state_d = ST_DONE;
      ST_DIV:  if (cnt_q == 32'd1) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // State, operand latch, shared MUL/DIV counter and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      cnt_q   <= '0;
      early_q <= 1'b0;
      md_res  <= '0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        op_q    <= md_op;
        op1_q   <= src1;
        op2_q   <= src2;
        cnt_q   <= in_is_mul_c ? 32'(MUL_LAT) : 32'(DIV_ITER);
        early_q <= early_c;
      end else if (state_q == ST_MUL || state_q == ST_DIV) begin
        cnt_q <= cnt_q - 32'd1;
      end
      if (state_d == ST_DONE && state_q != ST_DONE) md_res <= res_c;
    end
  end

  div_iter u_div_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_c && !in_is_mul_c),
    .step     (state_q == ST_DIV),
    .dividend (in_a_mag_c),
    .divisor  (in_b_mag_c),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  // Product: sign-extend only for mulh.w; low half is sign-agnostic
  assign mul_a_c = op_q[MD_MULH_W] ? {{XLEN{op1_q[XLEN-1]}}, op1_q} : {{XLEN{1'b0}}, op1_q};
  assign mul_b_c = op_q[MD_MULH_W] ? {{XLEN{op2_q[XLEN-1]}}, op2_q} : {{XLEN{1'b0}}, op2_q};
  assign prod_c  = mul_a_c * mul_b_c;

  // Divide sign fix-up and divide-by-zero override
  always_comb begin
    sgn_div_c = op_q[MD_DIV_W] | op_q[MD_MOD_W];
    q_mag_c   = early_q ? '0 : div_quo;
    r_mag_c   = early_q ? mag(op1_q, sgn_div_c) : div_rem;
    q_fix_c   = (sgn_div_c && (op1_q[XLEN-1] ^ op2_q[XLEN-1])) ? (~q_mag_c + XLEN'(1)) : q_mag_c;
    r_fix_c   = (sgn_div_c && op1_q[XLEN-1]) ? (~r_mag_c + XLEN'(1)) : r_mag_c;
    if (op2_q == '0) begin
      q_fix_c = '1;
      r_fix_c = op1_q;
    end
  end

  // Result select by latched op
  always_comb begin
    res_c = '0;
    unique case (1'b1)
      op_q[MD_MUL_W]:                    res_c = prod_c[XLEN-1:0];
      op_q[MD_MULH_W], op_q[MD_MULH_WU]: res_c = prod_c[2*XLEN-1:XLEN];
      op_q[MD_DIV_W],  op_q[MD_DIV_WU]:  res_c = q_fix_c;
      op_q[MD_MOD_W],  op_q[MD_MOD_WU]:  res_c = r_fix_c;
      default:                           res_c = '0;
    endcase
  end

  assign md_ready = (state_q == ST_IDLE);
  assign md_busy  = (state_q != ST_IDLE);
  assign cul_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Self-checking bench for md_seq_ctrl against an arithmetic reference model.
module tb_md_seq_ctrl;

  localparam int unsigned MUL_LAT  = 2;
  localparam int unsigned DIV_ITER = 32;
  localparam int          MAX_WAIT = 200;

  logic        clk = 1'b0;
  logic        rst, md_valid, flush, out_ready;
  logic [6:0]  md_op;
  logic [31:0] src1, src2;
  logic        md_ready, md_busy, cul_done;
  logic [31:0] md_res;

  int tests_run = 0;
  int tests_failed = 0;

  md_seq_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITER(DIV_ITER)) dut (
    .clk(clk), .rst(rst), .md_valid(md_valid), .md_op(md_op),
    .src1(src1), .src2(src2), .flush(flush), .out_ready(out_ready),
    .md_ready(md_ready), .md_busy(md_busy), .cul_done(cul_done), .md_res(md_res)
  );

  always #5 clk = ~clk;

  // Reference result from plain integer arithmetic
  function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    bit is_div, sgn;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    is_div = (op == 3) || (op == 5);
    sgn = (op == 3) || (op == 4);
    case (op)
      0: begin p = 64'(sa * sb); return p[31:0]; end
      1: begin p = 64'(sa * sb); return p[63:32]; end
      2: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      default: begin
        if (b == 32'd0) return is_div ? 32'hFFFF_FFFF : a;
        if (sgn) return is_div ? 32'(sa / sb) : 32'(sa % sb);
        return is_div ? (a / b) : (a % b);
      end
    endcase
  endfunction

  function automatic longint absval(input logic [31:0] v, input bit sgn);
    longint x;
    x = sgn ? longint'($signed(v)) : longint'({32'b0, v});
    return (x < 0) ? -x : x;
  endfunction

  // Cycle (accept edge = 0) in which cul_done is first high
  function automatic int exp_cycles(input int op, input logic [31:0] a, input logic [31:0] b);
    bit sgn;
    sgn = (op == 3) || (op == 4);
    if (op < 3) return int'(MUL_LAT) + 1;
`ifdef MD_EARLY_OUT_EN
    if (b != 32'd0 && absval(a, sgn) < absval(b, sgn)) return 2;
`endif
    return int'(DIV_ITER) + 2;
  endfunction

  // Issue one op, wait for cul_done, sample result, consume it
  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int cyc, output bit seen);
    md_valid = 1'b1; md_op = 7'(1 << op); src1 = a; src2 = b;
    @(posedge clk); #1;
    md_valid = 1'b0; md_op = 7'($urandom); src1 = $urandom; src2 = $urandom;
    cyc = 1; seen = cul_done;
    while (!seen && cyc < MAX_WAIT) begin
      @(posedge clk); #1; cyc++; seen = cul_done;
    end
    res = md_res;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input int op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res, exp_res;
    int cyc, exp_cyc;
    bit seen;
    exp_res = model(op, a, b);
    exp_cyc = exp_cycles(op, a, b);
    run_op(op, a, b, res, cyc, seen);
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL %s timeout: cul_done never rose (op %0d a %h b %h)", name, op, a, b);
    end else begin
      if (res !== exp_res) begin
        tests_failed++;
        $display("FAIL %s result op %0d a %h b %h: got %h expected %h", name, op, a, b, res, exp_res);
      end
      tests_run++;
      if (cyc !== exp_cyc) begin
        tests_failed++;
        $display("FAIL %s latency op %0d: got cycle %0d expected %0d", name, op, cyc, exp_cyc);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; md_valid = 1'b0; md_op = '0; src1 = '0; src2 = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    tests_run += 4;
    if (md_ready !== 1'b1) begin tests_failed++; $display("FAIL reset md_ready got %b expected 1", md_ready); end
    if (md_busy !== 1'b0) begin tests_failed++; $display("FAIL reset md_busy got %b expected 0", md_busy); end
    if (cul_done !== 1'b0) begin tests_failed++; $display("FAIL reset cul_done got %b expected 0", cul_done); end
    if (md_res !== 32'd0) begin tests_failed++; $display("FAIL reset md_res got %h expected 0", md_res); end
  endtask

  task automatic test_mul();
    check_op("mul_w_7xneg3", 0, 32'd7, 32'hFFFF_FFFD);
    check_op("mulh_wu_ones", 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_op("mulh_w_ones", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 15; i++)
      check_op("mul_rand", $urandom_range(0, 2), $urandom, $urandom);
  endtask

  task automatic test_div();
    logic [31:0] a, b;
    check_op("div_w_neg7_2", 3, 32'hFFFF_FFF9, 32'd2);
    check_op("mod_w_neg7_2", 4, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 1000));
        2: b = -32'($urandom_range(1, 1000));
        default: begin b = $urandom; a = 32'($urandom_range(0, 50)); end
      endcase
      check_op("div_rand", $urandom_range(3, 6), a, b);
    end
  endtask

  task automatic test_corner();
    check_op("div_wu_by0", 5, 32'd5, 32'd0);
    check_op("mod_wu_by0", 6, 32'd5, 32'd0);
    check_op("div_w_by0", 3, 32'hFFFF_FFF0, 32'd0);
    check_op("mod_w_by0", 4, 32'hFFFF_FFF0, 32'd0);
    check_op("div_w_ovf", 3, 32'h8000_0000, 32'hFFFF_FFFF);
    check_op("mod_w_ovf", 4, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_invalid_op();
    logic [6:0] bad [3];
    bad[0] = 7'b0000000; bad[1] = 7'b0001001; bad[2] = 7'b1100000;
    for (int i = 0; i < 3; i++) begin
      md_valid = 1'b1; md_op = bad[i]; src1 = 32'd9; src2 = 32'd3;
      @(posedge clk); #1;
      md_valid = 1'b0;
      tests_run++;
      if (md_busy !== 1'b0 || md_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL invalid_op %b accepted: busy %b ready %b expected 0/1", bad[i], md_busy, md_ready);
      end
    end
    // flush blocks acceptance in IDLE
    md_valid = 1'b1; md_op = 7'b0000001; flush = 1'b1;
    @(posedge clk); #1;
    md_valid = 1'b0; flush = 1'b0;
    tests_run++;
    if (md_busy !== 1'b0) begin tests_failed++; $display("FAIL flush_blocks_accept busy got %b expected 0", md_busy); end
  endtask

  task automatic test_flush();
    bit rose;
    md_valid = 1'b1; md_op = 7'(1 << 3); src1 = 32'd1000; src2 = 32'd7;
    @(posedge clk); #1;
    md_valid = 1'b0;
    rose = 1'b0;
    for (int c = 1; c < 10; c++) begin
      rose |= cul_done;
      if (c == 5) begin
        tests_run++;
        if (md_busy !== 1'b1 || md_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL div_inflight busy %b ready %b expected 1/0", md_busy, md_ready);
        end
      end
      @(posedge clk); #1;
    end
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    rose |= cul_done;
    tests_run++;
    if (md_ready !== 1'b1 || rose) begin
      tests_failed++;
      $display("FAIL flush_div ready %b expected 1, cul_done_seen %b expected 0", md_ready, rose);
    end
    check_op("mul_after_flush", 0, 32'd3, 32'd4);
  endtask

  task automatic test_hold();
    logic [31:0] exp_res;
    int cyc;
    exp_res = model(0, 32'h1234_5678, 32'd9);
    md_valid = 1'b1; md_op = 7'b0000001; src1 = 32'h1234_5678; src2 = 32'd9;
    @(posedge clk); #1;
    md_valid = 1'b0;
    cyc = 1;
    while (!cul_done && cyc < MAX_WAIT) begin @(posedge clk); #1; cyc++; end
    for (int k = 0; k < 5; k++) begin
      src1 = $urandom; src2 = $urandom;
      tests_run++;
      if (cul_done !== 1'b1 || md_res !== exp_res || md_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_done k=%0d done %b res %h ready %b expected 1 %h 0", k, cul_done, md_res, md_ready, exp_res);
      end
      @(posedge clk); #1;
    end
    // exit DONE with a valid op offered the same cycle: must not be taken
    out_ready = 1'b1; md_valid = 1'b1; md_op = 7'b0000001;
    @(posedge clk); #1;
    out_ready = 1'b0; md_valid = 1'b0;
    tests_run++;
    if (md_busy !== 1'b0 || cul_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_exit busy %b done %b expected 0 0", md_busy, cul_done);
    end
    // flush overrides a held result
    md_valid = 1'b1; md_op = 7'b0000100; src1 = 32'd5; src2 = 32'd6;
    @(posedge clk); #1;
    md_valid = 1'b0;
    repeat (MUL_LAT) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests_run++;
    if (cul_done !== 1'b0 || md_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_done done %b ready %b expected 0 1", cul_done, md_ready);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++)
      check_op("b2b", $urandom_range(0, 6), $urandom, 32'($urandom_range(0, 3) == 0 ? 0 : $urandom));
  endtask

  task automatic test_early();
    check_op("early_div_wu_3_10", 5, 32'd3, 32'd10);
    check_op("early_mod_w_neg3_10", 4, 32'hFFFF_FFFD, 32'd10);
  endtask

  task automatic test_reset_mid();
    md_valid = 1'b1; md_op = 7'(1 << 5); src1 = 32'hDEAD_BEEF; src2 = 32'd3;
    @(posedge clk); #1;
    md_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (md_ready !== 1'b1 || md_busy !== 1'b0 || cul_done !== 1'b0 || md_res !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_mid ready %b busy %b done %b res %h expected 1 0 0 0", md_ready, md_busy, cul_done, md_res);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_corner();
    test_invalid_op();
    test_flush();
    test_hold();
    test_back_to_back();
    test_early();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
